fetch_bp: RTL and testbench
===========================

# fetch_bp

Parametrised instruction-fetch stage with a direct-mapped branch target buffer (BTB) and 2-bit saturating predictors. Holds the PC, drives the instruction-memory address, and selects the next PC. The next PC is either the sequential PC, the predicted target, or a redirect resolved by ID. It sits in front of the IF/ID register and replaces the fixed four-way next-PC mux fetch stage. Redirect and BTB training come from ID.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_3000, PC value loaded on reset.
- `IM_ADDR_W`, 10, width of the word address driven to instruction memory.
- `BTB_ENTRIES`, 16, number of BTB entries; must be a power of two, ≥2. `IDX_W = log2(BTB_ENTRIES)`.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `stall`  in  1  1 = hold PC (hazard unit).
- `redirect_valid`  in  1  ID found a misprediction.
- `redirect_pc`  in  32  correct next PC; bits [1:0] are ignored.
- `upd_valid`  in  1  ID resolved a control instruction (branch/j/jal/jr).
- `upd_pc`  in  32  PC of the resolved instruction.
- `upd_taken`  in  1  resolved direction; jumps are always 1.
- `upd_target`  in  32  resolved target.
- `imem_addr`  out  IM_ADDR_W  equals `pc_cur[IM_ADDR_W+1:2]`.
- `imem_rdata`  in  32  combinational IM read data.
- `pc_cur`  out  32  current fetch PC.
- `pc_if`  out  32  `pc_cur + 4`, modulo 2^32.
- `instr_if`  out  32  equals `imem_rdata`.
- `pred_taken_if`  out  1  prediction for `pc_cur`.
- `pred_target_if`  out  32  predicted next PC. ID compares its resolved next PC against this.

## Operation
- BTB entry fields:
  - `valid`
  - `tag` = `pc[31:IDX_W+2]`
  - `target[31:2]`
  - `ctr[1:0]` (SNT=00, WNT=01, WT=10, ST=11)
- Index = `pc[IDX_W+1:2]`.
- Lookup (combinational on `pc_cur`):
  - hit = valid && tag match.
  - `pred_taken_if` = hit && `ctr[1]`.
  - `pred_target_if` = `{target,2'b00}` if `pred_taken_if`, else `pc_if`.
- Next-PC priority:
  - !rst_n → `RESET_PC`.
  - redirect_valid → `{redirect_pc[31:2],2'b00}`. Redirect beats stall.
  - stall → hold.
  - otherwise → `pred_target_if`.
- Update on the clock edge when `upd_valid`, indexed by `upd_pc`:
  - Hit, taken: ctr saturating +1; target ← `upd_target[31:2]`.
  - Hit, not taken: ctr saturating −1; target unchanged.
  - Miss, taken: allocate or overwrite. valid=1, tag, target; ctr=WT.
  - Miss, not taken: no change.
- BTB updates are independent of `stall` and `redirect_valid`.
- Lookup and update at the same index in the same cycle: lookup sees the old contents. There is no bypass.
- Reset clears all `valid` bits and sets all `ctr` to WNT. Tag and target fields need no reset.

## Timing
- Zero-latency lookup: the prediction is valid in the same cycle as `pc_cur`, from flops.
- PC register has one cycle latency. The selected next PC appears on `pc_cur` after the edge.
- An update affects a lookup from the cycle after the edge on which it is written.
- Reset assertion is asynchronous and can occur mid-operation.
  - Immediately: `pc_cur`=`RESET_PC`, `pc_if`=`RESET_PC+4`, `pred_taken_if`=0, `pred_target_if`=`RESET_PC+4`.
  - First sequential fetch happens on the first edge after deassertion.
- PC wraps 0xFFFF_FFFC → 0x0000_0000 when sequential.

## Structure
- Shared package/header `fetch_pkg`:
  - counter encodings SNT/WNT/WT/ST
  - BTB entry struct or field widths
  - default `RESET_PC`
- Sub-module `btb`: owns storage, the lookup port and the update port. Parameters `BTB_ENTRIES`; ports `clk`, `rst_n`.
- `fetch_bp` top-level contents:
  - PC register
  - next-PC priority mux
  - IM address slice

## Test plan
Defaults: `RESET_PC`=0x3000, `BTB_ENTRIES`=16.
- **Reset.** Assert `rst_n`=0 mid-run → `pc_cur`=0x3000 without waiting for a clock. After release → 0x3000, 0x3004, 0x3008 on successive cycles; `pred_taken_if`=0; `imem_addr`=0xC00, 0xC01, 0xC02.
- **Allocate.** `upd_valid` with `upd_pc`=0x3008, taken, target 0x3020. Next fetch of 0x3008 → `pred_taken_if`=1, `pred_target_if`=0x3020, then `pc_cur`=0x3020.
- **Hysteresis.**
  - Same entry, second taken update → ST.
  - First not-taken → WT, still predicts 0x3020.
  - Second not-taken → WNT; 0x3008 predicts 0x300C.
  - Not-taken miss at 0x3100 → no allocation.
- **Alias.** 0x3048 shares index 2 with 0x3008, different tag.
  - Fetch 0x3048 → `pred_taken_if`=0.
  - Taken update at 0x3048, target 0x3080 → evicts the entry; 0x3008 now misses.
- **Stall/redirect.**
  - `stall`=1 for 3 cycles → `pc_cur` and `instr_if` held.
  - `redirect_valid`=1 with `stall`=1 and `redirect_pc`=0x3101 → `pc_cur`=0x3100 next cycle.
- **Same-cycle update/lookup.** `pc_cur`=0x3010 while a taken update to 0x3010 (target 0x3040) is written → this cycle `pred_taken_if`=0. The next lookup of 0x3010 predicts 0x3040.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch stage: predictor counter encodings,
// field widths and the default reset PC.
package fetch_pkg;

    localparam int unsigned PC_W    = 32;
    localparam int unsigned PCW_W   = 30;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_e;

    // Saturating move toward strongly-taken.
    function automatic ctr_e ctr_inc(input ctr_e c);
        ctr_e r;
        case (c)
            CTR_SNT: r = CTR_WNT;
            CTR_WNT: r = CTR_WT;
            default: r = CTR_ST;
        endcase
        return r;
    endfunction

    // Saturating move toward strongly-not-taken.
    function automatic ctr_e ctr_dec(input ctr_e c);
        ctr_e r;
        case (c)
            CTR_ST:  r = CTR_WT;
            CTR_WT:  r = CTR_WNT;
            default: r = CTR_SNT;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/btb.sv
// Direct-mapped branch target buffer with 2-bit counters; combinational
// lookup port and a single clocked update port, both on word addresses.
module btb
    import fetch_pkg::*;
#(
    parameter int unsigned BTB_ENTRIES = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PCW_W-1:0] lkp_pc_w,
    output logic             lkp_taken_c,
    output logic [PCW_W-1:0] lkp_target_c,
    input  logic             upd_valid,
    input  logic [PCW_W-1:0] upd_pc_w,
    input  logic             upd_taken,
    input  logic [PCW_W-1:0] upd_target_w
);

    localparam int unsigned IDX_W = $clog2(BTB_ENTRIES);
    localparam int unsigned TAG_W = PCW_W - IDX_W;

    logic             valid_q [BTB_ENTRIES];
    logic             valid_d [BTB_ENTRIES];
    ctr_e             ctr_q   [BTB_ENTRIES];
    ctr_e             ctr_d   [BTB_ENTRIES];
    logic [TAG_W-1:0] tag_q   [BTB_ENTRIES];
    logic [TAG_W-1:0] tag_d   [BTB_ENTRIES];
    logic [PCW_W-1:0] tgt_q   [BTB_ENTRIES];
    logic [PCW_W-1:0] tgt_d   [BTB_ENTRIES];

    logic [IDX_W-1:0] lkp_idx;
    logic [TAG_W-1:0] lkp_tag;
    logic             lkp_hit;
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_hit;

    assign lkp_idx = lkp_pc_w[IDX_W-1:0];
    assign lkp_tag = lkp_pc_w[PCW_W-1:IDX_W];
    assign upd_idx = upd_pc_w[IDX_W-1:0];
    assign upd_tag = upd_pc_w[PCW_W-1:IDX_W];

    // Lookup reads only flop outputs, so a same-cycle write is not visible.
    assign lkp_hit      = valid_q[lkp_idx] && (tag_q[lkp_idx] == lkp_tag);
    assign lkp_taken_c  = lkp_hit && ctr_q[lkp_idx][1];
    assign lkp_target_c = tgt_q[lkp_idx];

    assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

    always_comb begin
        valid_d = valid_q;
        ctr_d   = ctr_q;
        tag_d   = tag_q;
        tgt_d   = tgt_q;
        if (upd_valid) begin
            if (upd_hit) begin
                if (upd_taken) begin
                    ctr_d[upd_idx] = ctr_inc(ctr_q[upd_idx]);
                    tgt_d[upd_idx] = upd_target_w;
                end else begin
                    ctr_d[upd_idx] = ctr_dec(ctr_q[upd_idx]);
                end
            end else if (upd_taken) begin
                valid_d[upd_idx] = 1'b1;
                ctr_d[upd_idx]   = CTR_WT;
                tag_d[upd_idx]   = upd_tag;
                tgt_d[upd_idx]   = upd_target_w;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < BTB_ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= CTR_WNT;
            end
        end else begin
            valid_q <= valid_d;
            ctr_q   <= ctr_d;
        end
    end

    // Tag and target are qualified by valid, so they carry no reset.
    always_ff @(posedge clk) begin
        tag_q <= tag_d;
        tgt_q <= tgt_d;
    end

endmodule

// File: rtl/fetch_bp.sv
// Instruction-fetch stage: PC register, next-PC selection between redirect,
// hold and BTB prediction, and the instruction-memory address slice.
module fetch_bp
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
    parameter int unsigned IM_ADDR_W   = 10,
    parameter int unsigned BTB_ENTRIES = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 stall,
    input  logic                 redirect_valid,
    input  logic [31:0]          redirect_pc,
    input  logic                 upd_valid,
    input  logic [31:0]          upd_pc,
    input  logic                 upd_taken,
    input  logic [31:0]          upd_target,
    output logic [IM_ADDR_W-1:0] imem_addr,
    input  logic [31:0]          imem_rdata,
    output logic [31:0]          pc_cur,
    output logic [31:0]          pc_if,
    output logic [31:0]          instr_if,
    output logic                 pred_taken_if,
    output logic [31:0]          pred_target_if
);

    logic [PC_W-1:0]  pc_q;
    logic [PC_W-1:0]  pc_d;
    logic [PCW_W-1:0] btb_target;
    logic             unused_low_bits;

    assign unused_low_bits = ^{redirect_pc[1:0], upd_pc[1:0], upd_target[1:0]};

    btb #(
        .BTB_ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .clk          (clk),
        .rst_n        (rst_n),
        .lkp_pc_w     (pc_q[31:2]),
        .lkp_taken_c  (pred_taken_if),
        .lkp_target_c (btb_target),
        .upd_valid    (upd_valid),
        .upd_pc_w     (upd_pc[31:2]),
        .upd_taken    (upd_taken),
        .upd_target_w (upd_target[31:2])
    );

    assign pc_cur         = pc_q;
    assign pc_if          = pc_q + 32'd4;
    assign pred_target_if = pred_taken_if ? {btb_target, 2'b00} : pc_if;
    assign imem_addr      = pc_q[IM_ADDR_W+1:2];
    assign instr_if       = imem_rdata;

    // Redirect outranks a hazard stall.
    always_comb begin
        pc_d = pred_target_if;
        if (redirect_valid) begin
            pc_d = {redirect_pc[31:2], 2'b00};
        end else if (stall) begin
            pc_d = pc_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: tb/tb_fetch_bp.sv
// Directed bench for fetch_bp: reset, BTB allocate/hysteresis/alias,
// stall and redirect, PC wrap and same-cycle update/lookup.
module tb_fetch_bp;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic [11:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] pc_cur;
    logic [31:0] pc_if;
    logic [31:0] instr_if;
    logic        pred_taken_if;
    logic [31:0] pred_target_if;

    int errors = 0;
    int checks = 0;

    fetch_bp #(
        .RESET_PC    (32'h0000_3000),
        .IM_ADDR_W   (12),
        .BTB_ENTRIES (16)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_taken      (upd_taken),
        .upd_target     (upd_target),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .pc_cur         (pc_cur),
        .pc_if          (pc_if),
        .instr_if       (instr_if),
        .pred_taken_if  (pred_taken_if),
        .pred_target_if (pred_target_if)
    );

    assign imem_rdata = 32'hA5A5_0000 | {20'd0, imem_addr};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        step();
        redirect_valid = 1'b0;
    endtask

    task automatic train(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
        upd_valid  = 1'b1;
        upd_pc     = pc;
        upd_taken  = taken;
        upd_target = tgt;
        step();
        upd_valid  = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        checks++; if (pc_cur !== 32'h3000) begin errors++; $display("FAIL reset_pc got=%h exp=%h", pc_cur, 32'h3000); end
        checks++; if (pc_if !== 32'h3004) begin errors++; $display("FAIL reset_pc_if got=%h exp=%h", pc_if, 32'h3004); end
        checks++; if (imem_addr !== 12'hC00) begin errors++; $display("FAIL reset_addr got=%h exp=%h", imem_addr, 12'hC00); end
        checks++; if (pred_taken_if !== 1'b0) begin errors++; $display("FAIL reset_pt got=%b exp=0", pred_taken_if); end
        checks++; if (pred_target_if !== 32'h3004) begin errors++; $display("FAIL reset_ptgt got=%h exp=%h", pred_target_if, 32'h3004); end
        step();
        checks++; if (pc_cur !== 32'h3004) begin errors++; $display("FAIL seq1_pc got=%h exp=%h", pc_cur, 32'h3004); end
        step();
        checks++; if (pc_cur !== 32'h3008) begin errors++; $display("FAIL seq2_pc got=%h exp=%h", pc_cur, 32'h3008); end
        // Asynchronous assertion in the middle of a cycle.
        #2 rst_n = 1'b0;
        #1;
        checks++; if (pc_cur !== 32'h3000) begin errors++; $display("FAIL async_rst_pc got=%h exp=%h", pc_cur, 32'h3000); end
        checks++; if (pred_target_if !== 32'h3004) begin errors++; $display("FAIL async_rst_ptgt got=%h exp=%h", pred_target_if, 32'h3004); end
        checks++; if (pred_taken_if !== 1'b0) begin errors++; $display("FAIL async_rst_pt got=%b exp=0", pred_taken_if); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        checks++; if (pc_cur !== 32'h3000) begin errors++; $display("FAIL rel_pc0 got=%h exp=%h", pc_cur, 32'h3000); end
        step();
        checks++; if (pc_cur !== 32'h3004 || imem_addr !== 12'hC01) begin errors++; $display("FAIL rel_pc1 got=%h/%h exp=3004/c01", pc_cur, imem_addr); end
        step();
        checks++; if (pc_cur !== 32'h3008 || imem_addr !== 12'hC02) begin errors++; $display("FAIL rel_pc2 got=%h/%h exp=3008/c02", pc_cur, imem_addr); end
        checks++; if (pred_taken_if !== 1'b0) begin errors++; $display("FAIL rel_pt got=%b exp=0", pred_taken_if); end
    endtask

    task automatic test_allocate();
        redirect_to(32'h3000);
        checks++; if (pc_cur !== 32'h3000) begin errors++; $display("FAIL alloc_redir got=%h exp=%h", pc_cur, 32'h3000); end
        train(32'h3008, 1'b1, 32'h3020);
        checks++; if (pc_cur !== 32'h3004 || pred_taken_if !== 1'b0) begin errors++; $display("FAIL alloc_pc4 got=%h/%b exp=3004/0", pc_cur, pred_taken_if); end
        step();
        checks++; if (pred_taken_if !== 1'b1) begin errors++; $display("FAIL alloc_pt got=%b exp=1", pred_taken_if); end
        checks++; if (pred_target_if !== 32'h3020) begin errors++; $display("FAIL alloc_ptgt got=%h exp=%h", pred_target_if, 32'h3020); end
        step();
        checks++; if (pc_cur !== 32'h3020) begin errors++; $display("FAIL alloc_jump got=%h exp=%h", pc_cur, 32'h3020); end
    endtask

    task automatic test_hysteresis();
        stall = 1'b1;
        train(32'h3008, 1'b1, 32'h3020);
        train(32'h3008, 1'b0, 32'h0);
        checks++; if (pc_cur !== 32'h3020) begin errors++; $display("FAIL hyst_hold got=%h exp=%h", pc_cur, 32'h3020); end
        redirect_to(32'h3008);
        checks++; if (pred_taken_if !== 1'b1 || pred_target_if !== 32'h3020) begin errors++; $display("FAIL hyst_wt got=%b/%h exp=1/3020", pred_taken_if, pred_target_if); end
        train(32'h3008, 1'b0, 32'h0);
        checks++; if (pred_taken_if !== 1'b0 || pred_target_if !== 32'h300C) begin errors++; $display("FAIL hyst_wnt got=%b/%h exp=0/300c", pred_taken_if, pred_target_if); end
        train(32'h3100, 1'b0, 32'h3000);
        redirect_to(32'h3100);
        checks++; if (pc_cur !== 32'h3100 || pred_taken_if !== 1'b0) begin errors++; $display("FAIL hyst_nt_miss got=%h/%b exp=3100/0", pc_cur, pred_taken_if); end
    endtask

    task automatic test_alias();
        train(32'h3008, 1'b1, 32'h3020);
        redirect_to(32'h3008);
        checks++; if (pred_taken_if !== 1'b1 || pred_target_if !== 32'h3020) begin errors++; $display("FAIL alias_pre got=%b/%h exp=1/3020", pred_taken_if, pred_target_if); end
        redirect_to(32'h3048);
        checks++; if (pred_taken_if !== 1'b0 || pred_target_if !== 32'h304C) begin errors++; $display("FAIL alias_tag got=%b/%h exp=0/304c", pred_taken_if, pred_target_if); end
        train(32'h3048, 1'b1, 32'h3080);
        checks++; if (pred_taken_if !== 1'b1 || pred_target_if !== 32'h3080) begin errors++; $display("FAIL alias_alloc got=%b/%h exp=1/3080", pred_taken_if, pred_target_if); end
        redirect_to(32'h3008);
        checks++; if (pred_taken_if !== 1'b0 || pred_target_if !== 32'h300C) begin errors++; $display("FAIL alias_evict got=%b/%h exp=0/300c", pred_taken_if, pred_target_if); end
        stall = 1'b0;
    endtask

    task automatic test_stall_redirect();
        redirect_to(32'h3200);
        step();
        step();
        checks++; if (pc_cur !== 32'h3208) begin errors++; $display("FAIL stall_pre got=%h exp=%h", pc_cur, 32'h3208); end
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (pc_cur !== 32'h3208 || instr_if !== 32'hA5A5_0C82) begin errors++; $display("FAIL stall_hold%0d got=%h/%h exp=3208/a5a50c82", i, pc_cur, instr_if); end
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h3101;
        step();
        redirect_valid = 1'b0;
        stall = 1'b0;
        checks++; if (pc_cur !== 32'h3100 || imem_addr !== 12'hC40) begin errors++; $display("FAIL redir_stall got=%h/%h exp=3100/c40", pc_cur, imem_addr); end
        redirect_to(32'hFFFF_FFFC);
        checks++; if (pc_if !== 32'h0 || imem_addr !== 12'hFFF) begin errors++; $display("FAIL wrap_pre got=%h/%h exp=0/fff", pc_if, imem_addr); end
        step();
        checks++; if (pc_cur !== 32'h0 || imem_addr !== 12'h000) begin errors++; $display("FAIL wrap got=%h/%h exp=0/000", pc_cur, imem_addr); end
    endtask

    task automatic test_same_cycle();
        redirect_to(32'h3010);
        stall      = 1'b1;
        upd_valid  = 1'b1;
        upd_pc     = 32'h3010;
        upd_taken  = 1'b1;
        upd_target = 32'h3040;
        #1;
        checks++; if (pred_taken_if !== 1'b0 || pred_target_if !== 32'h3014) begin errors++; $display("FAIL same_old got=%b/%h exp=0/3014", pred_taken_if, pred_target_if); end
        step();
        upd_valid = 1'b0;
        checks++; if (pc_cur !== 32'h3010 || pred_taken_if !== 1'b1 || pred_target_if !== 32'h3040) begin errors++; $display("FAIL same_new got=%h/%b/%h exp=3010/1/3040", pc_cur, pred_taken_if, pred_target_if); end
        stall = 1'b0;
        step();
        checks++; if (pc_cur !== 32'h3040) begin errors++; $display("FAIL same_jump got=%h exp=%h", pc_cur, 32'h3040); end
    endtask

    initial begin
        rst_n          = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        upd_valid      = 1'b0;
        upd_pc         = 32'h0;
        upd_taken      = 1'b0;
        upd_target     = 32'h0;
        test_reset();
        test_allocate();
        test_hysteresis();
        test_alias();
        test_stall_redirect();
        test_same_cycle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
